// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM encoding, state byte indexing and GF(2^8) helpers.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARK   = 3'd1,
    ST_SUB   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_MIX   = 3'd4,
    ST_DONE  = 3'd5
  } aes_state_e;

  // Element 0 multiplies the row's own byte; higher elements walk down the column.
  localparam logic [0:3][7:0] MIX_FWD = {8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [0:3][7:0] MIX_INV = {8'h0e, 8'h0b, 8'h0d, 8'h09};

  function automatic int row_of(input int i);
    return i % 4;
  endfunction

  function automatic int col_of(input int i);
    return i / 4;
  endfunction

  // Column wraps modulo 4, so negative offsets are legal.
  function automatic int byte_idx(input int r, input int c);
    return (r & 3) + 4 * (c & 3);
  endfunction

  // Source byte for destination byte i of ShiftRows (left rotate) or its inverse.
  function automatic int shift_src(input int i, input logic inv);
    return byte_idx(row_of(i), inv ? col_of(i) - row_of(i) : col_of(i) + row_of(i));
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] mix_coef(input logic inv, input int k);
    return inv ? MIX_INV[k & 3] : MIX_FWD[k & 3];
  endfunction

endpackage

// File: rtl/aes_mix_column.sv
// One MixColumns / InvMixColumns column; row 0 byte sits in the top 8 bits.
module aes_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  input  logic        inv_i,
  output logic [31:0] col_o
);

  logic [3:0][7:0] a;
  logic [3:0][7:0] m;

  always_comb begin
    for (int j = 0; j < 4; j++) a[j] = col_i[31-8*j -: 8];
  end

  always_comb begin
    m = '0;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        m[r] = m[r] ^ gmul(mix_coef(inv_i, j - r), a[j]);
  end

  always_comb begin
    for (int r = 0; r < 4; r++) col_o[31-8*r -: 8] = m[r];
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128 encrypt/decrypt sequencer over a 128-bit state register, sharing one
// external byte-wide S-box and reading round keys from an external key store.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR       = AES_NR,
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         decrypt,
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic         busy,
  output logic         done,
  output logic [3:0]   round_idx,
  input  logic [127:0] round_key,
  output logic         sbox_inv,
  output logic [7:0]   sbox_in,
  input  logic [7:0]   sbox_out
);

  localparam logic [3:0] NR_L     = 4'(NR);
  localparam logic [4:0] LAT5     = 5'(SBOX_LAT);
  localparam logic [4:0] SUB_LAST = 5'(16 + SBOX_LAT - 1);

  aes_state_e   state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] dout_q, dout_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [4:0]   bc_q, bc_d;
  logic         dec_q, dec_d;

  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [3:0]   wr_idx;
  logic         last_ark;

  always_comb begin
    shifted = '0;
    for (int i = 0; i < 16; i++)
      shifted[8*(15-i) +: 8] = st_q[8*(15-shift_src(i, dec_q)) +: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_mix_column u_mix (
      .col_i (st_q[127-32*c -: 32]),
      .inv_i (dec_q),
      .col_o (mixed[127-32*c -: 32])
    );
  end

  // S-box results trail the issued byte by SBOX_LAT cycles.
  assign wr_idx   = 4'(bc_q - LAT5);
  assign last_ark = dec_q ? (rnd_q == 4'd0) : (rnd_q == NR_L);

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    dout_d  = dout_q;
    rnd_d   = rnd_q;
    bc_d    = bc_q;
    dec_d   = dec_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_ARK;
          st_d    = data_in;
          dec_d   = decrypt;
          rnd_d   = decrypt ? NR_L : 4'd0;
          bc_d    = '0;
        end
      end
      ST_ARK: begin
        st_d = st_q ^ round_key;
        bc_d = '0;
        if (last_ark) begin
          state_d = ST_DONE;
          dout_d  = st_q ^ round_key;
        end else if (!dec_q) begin
          rnd_d   = rnd_q + 4'd1;
          state_d = ST_SUB;
        end else begin
          rnd_d   = rnd_q - 4'd1;
          state_d = (rnd_q == NR_L) ? ST_SHIFT : ST_MIX;
        end
      end
      ST_SUB: begin
        if (bc_q >= LAT5) st_d[8*(15-int'(wr_idx)) +: 8] = sbox_out;
        if (bc_q == SUB_LAST) begin
          bc_d    = '0;
          state_d = dec_q ? ST_ARK : ST_SHIFT;
        end else begin
          bc_d = bc_q + 5'd1;
        end
      end
      ST_SHIFT: begin
        st_d    = shifted;
        bc_d    = '0;
        if (dec_q)              state_d = ST_SUB;
        else if (rnd_q == NR_L) state_d = ST_ARK;
        else                    state_d = ST_MIX;
      end
      ST_MIX: begin
        st_d    = mixed;
        state_d = dec_q ? ST_SHIFT : ST_ARK;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      st_q    <= '0;
      dout_q  <= '0;
      rnd_q   <= '0;
      bc_q    <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      dout_q  <= dout_d;
      rnd_q   <= rnd_d;
      bc_q    <= bc_d;
      dec_q   <= dec_d;
    end
  end

  assign busy      = (state_q == ST_ARK) || (state_q == ST_SUB) ||
                     (state_q == ST_SHIFT) || (state_q == ST_MIX);
  assign done      = (state_q == ST_DONE);
  assign data_out  = dout_q;
  assign round_idx = rnd_q;
  assign sbox_inv  = dec_q;
  assign sbox_in   = (state_q == ST_SUB && !bc_q[4]) ? st_q[8*(15-int'(bc_q[3:0])) +: 8] : 8'h00;

endmodule
